// File: rtl/alsu_arbiter.sv
// alsu_arbiter: two-requester round-robin arbiter and sequencer for the shared 3-bit ALSU.
//
// Accepts packed ALSU commands over valid/ready and issues at most one per cycle on a
// registered command bus. Each issue slot is tracked through the ALSU's fixed pipeline, so
// every result comes back tagged with its requester ID and an error flag. A requester can
// lock the grant, which lets shift/rotate sequences run back-to-back on its accumulated `out`.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          command handshake for requester N (N = 0, 1)
//   reqN_cmd [15:0]           packed command: op, A, B, cin, serial_in, red_op_A/B,
//                             bypass_A/B, direction
//   reqN_lock                 keep the grant after this command
//   alsu_cmd [15:0]           registered command to the ALSU (IDLE word when nothing issues)
//   alsu_out [5:0]            ALSU result
//   rsp_valid/id/data/err     result strobe, requester ID, result, illegal-command flag
module alsu_arbiter #(
    parameter int unsigned ALSU_LATENCY = 2,
    parameter int unsigned MAX_LOCK     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_cmd,
    input  logic        req0_lock,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_cmd,
    input  logic        req1_lock,
    output logic [15:0] alsu_cmd,
    input  logic [5:0]  alsu_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [5:0]  rsp_data,
    output logic        rsp_err
);

    localparam int unsigned Depth = ALSU_LATENCY + 1;
    localparam int unsigned CntW  = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LOCK);
    // bypass_A=1 with A=0: the ALSU drives out=0 and its shift state is not preserved.
    localparam logic [15:0] IdleCmd = 16'h0004;

    typedef enum logic [1:0] {
        StUnlocked,
        StLock0,
        StLock1
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [15:0]     alsu_cmd_q, alsu_cmd_d;
    logic [Depth-1:0] trk_vld_q, trk_vld_d;
    logic [Depth-1:0] trk_id_q, trk_id_d;
    logic [Depth-1:0] trk_err_q, trk_err_d;

    logic        hs0, hs1, hs;
    logic        gnt_id;
    logic [15:0] gnt_cmd;
    logic        gnt_lock;
    logic        gnt_err;
    logic [2:0]  gnt_op;
    logic        owner;
    logic        own_valid, own_lock;

    // Readies depend only on state, rr and the valids.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            StUnlocked: begin
                req0_ready = !rr_q || !req1_valid;
                req1_ready = rr_q || !req0_valid;
            end
            StLock0: req0_ready = 1'b1;
            StLock1: req1_ready = 1'b1;
            default: ;
        endcase
    end

    assign hs0      = req0_valid && req0_ready;
    assign hs1      = req1_valid && req1_ready;
    assign hs       = hs0 || hs1;
    assign gnt_id   = hs1;
    assign gnt_cmd  = hs1 ? req1_cmd : req0_cmd;
    assign gnt_lock = hs1 ? req1_lock : req0_lock;
    assign gnt_op   = gnt_cmd[15:13];
    assign gnt_err  = (gnt_op >= 3'b110) ||
                      ((gnt_cmd[4] || gnt_cmd[3]) && (gnt_op >= 3'b010) &&
                       !gnt_cmd[2] && !gnt_cmd[1]);

    assign owner     = (state_q == StLock1);
    assign own_valid = owner ? req1_valid : req0_valid;
    assign own_lock  = owner ? req1_lock : req0_lock;
    assign cnt_inc   = lock_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            StUnlocked: begin
                if (hs) begin
                    rr_d = ~gnt_id;
                    // With MAX_LOCK=1 a locked command is already at its limit.
                    if (gnt_lock && (MAX_LOCK > 1)) begin
                        state_d    = gnt_id ? StLock1 : StLock0;
                        lock_cnt_d = CntW'(1);
                    end
                end
            end
            StLock0, StLock1: begin
                if (hs) begin
                    if (!gnt_lock || (cnt_inc >= MaxCnt)) begin
                        state_d    = StUnlocked;
                        rr_d       = ~owner;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = cnt_inc;
                    end
                end else if (!own_valid && !own_lock) begin
                    state_d    = StUnlocked;
                    rr_d       = ~owner;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = StUnlocked;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Issue slot tracking: one {valid, id, err} entry per cycle, tail lines up with alsu_out.
    always_comb begin
        alsu_cmd_d   = hs ? gnt_cmd : IdleCmd;
        trk_vld_d[0] = hs;
        trk_id_d[0]  = hs && gnt_id;
        trk_err_d[0] = hs && gnt_err;
        for (int unsigned i = 1; i < Depth; i++) begin
            trk_vld_d[i] = trk_vld_q[i-1];
            trk_id_d[i]  = trk_id_q[i-1];
            trk_err_d[i] = trk_err_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StUnlocked;
            rr_q       <= 1'b0;
            lock_cnt_q <= '0;
            alsu_cmd_q <= IdleCmd;
            trk_vld_q  <= '0;
            trk_id_q   <= '0;
            trk_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            alsu_cmd_q <= alsu_cmd_d;
            trk_vld_q  <= trk_vld_d;
            trk_id_q   <= trk_id_d;
            trk_err_q  <= trk_err_d;
        end
    end

    assign alsu_cmd  = alsu_cmd_q;
    assign rsp_valid = trk_vld_q[Depth-1];
    assign rsp_id    = trk_id_q[Depth-1];
    assign rsp_err   = trk_err_q[Depth-1];
    assign rsp_data  = rsp_valid ? alsu_out : 6'd0;

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb_alsu_arbiter: directed bench for alsu_arbiter with a small behavioural ALSU attached.
// A second instance with MAX_LOCK=4 covers the forced lock release.
module tb_alsu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_lock;
    logic        req1_valid, req1_ready, req1_lock;
    logic [15:0] req0_cmd, req1_cmd, alsu_cmd;
    logic [5:0]  alsu_out, rsp_data;
    logic        rsp_valid, rsp_id, rsp_err;

    logic        d2_req0_valid, d2_req0_ready, d2_req0_lock;
    logic        d2_req1_valid, d2_req1_ready, d2_req1_lock;
    logic [15:0] d2_req0_cmd, d2_req1_cmd, d2_alsu_cmd;
    logic [5:0]  d2_rsp_data;
    logic        d2_rsp_valid, d2_rsp_id, d2_rsp_err;

    always #5 clk = ~clk;

    alsu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_cmd   (req0_cmd),
        .req0_lock  (req0_lock),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_cmd   (req1_cmd),
        .req1_lock  (req1_lock),
        .alsu_cmd   (alsu_cmd),
        .alsu_out   (alsu_out),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    alsu_arbiter #(.ALSU_LATENCY(2), .MAX_LOCK(4)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (d2_req0_valid),
        .req0_ready (d2_req0_ready),
        .req0_cmd   (d2_req0_cmd),
        .req0_lock  (d2_req0_lock),
        .req1_valid (d2_req1_valid),
        .req1_ready (d2_req1_ready),
        .req1_cmd   (d2_req1_cmd),
        .req1_lock  (d2_req1_lock),
        .alsu_cmd   (d2_alsu_cmd),
        .alsu_out   (6'd0),
        .rsp_valid  (d2_rsp_valid),
        .rsp_id     (d2_rsp_id),
        .rsp_data   (d2_rsp_data),
        .rsp_err    (d2_rsp_err)
    );

    // Behavioural ALSU: input register then output register, two cycles of latency.
    logic [15:0] m_in_q;
    logic [5:0]  m_out_q;

    function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] o);
        logic [2:0] op, a, b;
        op = c[15:13];
        a  = c[12:10];
        b  = c[9:7];
        if (op >= 3'b110 || ((c[4] || c[3]) && op >= 3'b010 && !c[2] && !c[1])) return 6'd0;
        if (c[2]) return {3'b000, a};
        if (c[1]) return {3'b000, b};
        case (op)
            3'b000:  return c[4] ? {5'd0, &a} : (c[3] ? {5'd0, &b} : {3'b000, a & b});
            3'b001:  return c[4] ? {5'd0, ^a} : (c[3] ? {5'd0, ^b} : {3'b000, a ^ b});
            3'b010:  return 6'(a) + 6'(b) + 6'(c[6]);
            3'b011:  return 6'(a) * 6'(b);
            3'b100:  return c[0] ? {o[4:0], c[5]} : {c[5], o[5:1]};
            default: return c[0] ? {o[4:0], o[5]} : {o[0], o[5:1]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_in_q  <= 16'h0004;
            m_out_q <= 6'd0;
        end else begin
            m_in_q  <= alsu_cmd;
            m_out_q <= alsu_f(m_in_q, m_out_q);
        end
    end
    assign alsu_out = m_out_q;

    // Logs of handshakes and responses, sampled mid-cycle.
    int cyc = 0;
    int hs_cyc[$], hs_id[$];
    int rsp_cyc[$], rsp_idq[$], rsp_dataq[$], rsp_errq[$];
    int g2_id[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) begin
                hs_cyc.push_back(cyc);
                hs_id.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                hs_cyc.push_back(cyc);
                hs_id.push_back(1);
            end
            if (d2_req0_valid && d2_req0_ready) g2_id.push_back(0);
            if (d2_req1_valid && d2_req1_ready) g2_id.push_back(1);
        end
        if (rsp_valid) begin
            rsp_cyc.push_back(cyc);
            rsp_idq.push_back(int'(rsp_id));
            rsp_dataq.push_back(int'(rsp_data));
            rsp_errq.push_back(int'(rsp_err));
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Response i must pair with handshake i, three cycles later.
    task automatic check_rsp(input string tag, input int i, input int id, input int data,
                             input int err);
        if (i < rsp_cyc.size() && i < hs_cyc.size()) begin
            check_eq({tag, "_lat"}, rsp_cyc[i] - hs_cyc[i], 3);
            check_eq({tag, "_id"}, rsp_idq[i], id);
            check_eq({tag, "_data"}, rsp_dataq[i], data);
            check_eq({tag, "_err"}, rsp_errq[i], err);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic cin, input logic si,
                                       input logic ra, input logic rb, input logic ba,
                                       input logic bb, input logic dir);
        return {op, a, b, cin, si, ra, rb, ba, bb, dir};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        hs_cyc.delete();
        hs_id.delete();
        rsp_cyc.delete();
        rsp_idq.delete();
        rsp_dataq.delete();
        rsp_errq.delete();
        g2_id.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_lock = 1'b0; req1_lock = 1'b0;
        d2_req0_valid = 1'b0; d2_req1_valid = 1'b0;
        d2_req0_lock = 1'b0; d2_req1_lock = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    logic [15:0] add_cmd, c_a1, c_a2, c_a5, c_shl;

    initial begin
        req0_cmd = '0; req1_cmd = '0; d2_req0_cmd = '0; d2_req1_cmd = '0;
        add_cmd = mk(3'b010, 3'd3, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        c_a1    = mk(3'b000, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        c_a2    = mk(3'b000, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        c_a5    = mk(3'b000, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        c_shl   = mk(3'b100, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state
        do_reset();
        #1;
        check_eq("rst_alsu_cmd", int'(alsu_cmd), 16'h0004);
        check_eq("rst_rsp_valid", int'(rsp_valid), 0);
        check_eq("rst_rsp_id", int'(rsp_id), 0);
        check_eq("rst_rsp_err", int'(rsp_err), 0);
        check_eq("rst_rsp_data", int'(rsp_data), 0);
        check_eq("rst_req0_ready", int'(req0_ready), 1);
        check_eq("rst_req1_ready", int'(req1_ready), 1);

        // Single add: 3 + 4 + 1 = 8
        do_reset();
        req0_valid = 1'b1; req0_cmd = add_cmd;
        tick();
        req0_valid = 1'b0;
        check_eq("add_bus", int'(alsu_cmd), int'(add_cmd));
        repeat (5) tick();
        check_eq("add_nrsp", rsp_cyc.size(), 1);
        check_rsp("add", 0, 0, 8, 0);

        // Contention without lock: grants alternate
        do_reset();
        req0_valid = 1'b1; req0_cmd = c_a1;
        req1_valid = 1'b1; req1_cmd = c_a2;
        repeat (4) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) tick();
        check_eq("ct_nhs", hs_id.size(), 4);
        check_eq("ct_nrsp", rsp_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_id.size()) check_eq("ct_gnt", hs_id[i], i % 2);
            check_rsp("ct", i, i % 2, (i % 2 == 1) ? 2 : 1, 0);
        end

        // Locked burst: load 5, shift left twice with serial_in=1 -> 11, 23
        do_reset();
        req1_valid = 1'b1; req1_cmd = c_a2;
        req0_valid = 1'b1; req0_cmd = c_a5; req0_lock = 1'b1;
        #1 check_eq("lk_r1_c1", int'(req1_ready), 0);
        tick();
        req0_cmd = c_shl;
        #1 check_eq("lk_r1_c2", int'(req1_ready), 0);
        tick();
        req0_lock = 1'b0;
        #1 check_eq("lk_r1_c3", int'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        #1 check_eq("lk_r1_c4", int'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        repeat (5) tick();
        check_eq("lk_nhs", hs_id.size(), 4);
        check_eq("lk_nrsp", rsp_cyc.size(), 4);
        if (hs_id.size() >= 4) begin
            check_eq("lk_gnt3", hs_id[3], 1);
            check_eq("lk_gap", hs_cyc[3] - hs_cyc[2], 1);
        end
        check_rsp("lk0", 0, 0, 5, 0);
        check_rsp("lk1", 1, 0, 11, 0);
        check_rsp("lk2", 2, 0, 23, 0);
        check_rsp("lk3", 3, 1, 2, 0);

        // Owner drops valid but holds lock: the other requester waits
        do_reset();
        req0_valid = 1'b1; req0_cmd = c_a1; req0_lock = 1'b1;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1; req1_cmd = c_a2;
        #1 check_eq("hold_r1_a", int'(req1_ready), 0);
        tick();
        #1 check_eq("hold_r1_b", int'(req1_ready), 0);
        req0_lock = 1'b0;
        tick();
        #1 check_eq("hold_r1_rel", int'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        repeat (4) tick();

        // Errors are issued and flagged
        do_reset();
        req0_valid = 1'b1;
        req0_cmd = mk(3'b111, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        req0_cmd = mk(3'b011, 3'd3, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        req0_cmd = mk(3'b000, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        req0_valid = 1'b0;
        repeat (5) tick();
        check_eq("er_nrsp", rsp_cyc.size(), 3);
        check_rsp("er0", 0, 0, 0, 1);
        check_rsp("er1", 1, 0, 0, 1);
        check_rsp("er2", 2, 0, 1, 0);

        // Reset mid-flight drops the in-flight command and restores rr
        do_reset();
        req0_valid = 1'b1; req0_cmd = add_cmd;
        tick();
        req0_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 check_eq("rm_idle", int'(alsu_cmd), 16'h0004);
        req0_valid = 1'b1; req1_valid = 1'b1; req1_cmd = c_a2;
        #1;
        check_eq("rm_r0", int'(req0_ready), 1);
        check_eq("rm_r1", int'(req1_ready), 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) tick();
        check_eq("rm_nrsp", rsp_cyc.size(), 1);
        if (rsp_cyc.size() >= 1 && hs_cyc.size() >= 2) begin
            check_eq("rm_lat", rsp_cyc[0] - hs_cyc[1], 3);
            check_eq("rm_data", rsp_dataq[0], 8);
        end

        // Forced release with MAX_LOCK=4
        do_reset();
        d2_req0_valid = 1'b1; d2_req0_lock = 1'b1; d2_req0_cmd = c_a1;
        d2_req1_valid = 1'b1; d2_req1_cmd = c_a2;
        repeat (5) tick();
        d2_req0_valid = 1'b0; d2_req1_valid = 1'b0; d2_req0_lock = 1'b0;
        tick();
        check_eq("fr_ngnt", g2_id.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < g2_id.size()) check_eq("fr_gnt", g2_id[i], (i == 4) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
